// File: rtl/simt_reconv_stack.sv
// Per-warp SIMT reconvergence stack.
// Each warp tracks its active thread mask across nested divergent branches.
// A divergent branch runs the taken threads first. The first sync at the
// reconvergence point switches to the not-taken threads. The second sync
// restores the pre-branch mask and resumes after the sync instruction.
module simt_reconv_stack #(
  parameter  int NUM_WARPS   = 8,
  parameter  int NUM_THREADS = 8,
  parameter  int DEPTH       = 4,
  parameter  int PC_W        = 10,
  localparam int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           init_valid,
  input  logic [WID_W-1:0]               init_warp,
  input  logic [NUM_THREADS-1:0]         init_mask,
  input  logic                           br_valid,
  input  logic [WID_W-1:0]               br_warp,
  input  logic [NUM_THREADS-1:0]         br_taken,
  input  logic [PC_W-1:0]                br_target,
  input  logic [PC_W-1:0]                br_fallthru,
  input  logic                           sync_valid,
  input  logic [WID_W-1:0]               sync_warp,
  input  logic [PC_W-1:0]                sync_pc,
  output logic [NUM_WARPS*NUM_THREADS-1:0] active_mask_flat,
  output logic [NUM_WARPS-1:0]           redirect_vec,
  output logic [NUM_WARPS*PC_W-1:0]      redirect_pc_flat,
  output logic [NUM_WARPS-1:0]           stack_empty,
  output logic                           err_overflow,
  output logic                           err_underflow
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [NUM_THREADS-1:0] mask_t;
  typedef logic [PC_W-1:0]        pc_t;
  typedef logic [SP_W-1:0]        sp_t;
  typedef logic [IDX_W-1:0]       idx_t;

  localparam sp_t SP_FULL = sp_t'(DEPTH);
  localparam sp_t SP_ONE  = sp_t'(1);

  // Architectural per-warp state
  mask_t            mask_q        [NUM_WARPS];
  mask_t            mask_d        [NUM_WARPS];
  sp_t              sp_q          [NUM_WARPS];
  sp_t              sp_d          [NUM_WARPS];
  logic [DEPTH-1:0] pending_q     [NUM_WARPS];
  logic [DEPTH-1:0] pending_d     [NUM_WARPS];
  pc_t              redirect_pc_q [NUM_WARPS];
  pc_t              redirect_pc_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] redirect_q, redirect_d;
  logic             err_ov_q, err_ov_d;
  logic             err_un_q, err_un_d;

  // Stack payload; the pending bit decides whether an entry is meaningful
  mask_t alt_mask_q   [NUM_WARPS][DEPTH];
  pc_t   alt_pc_q     [NUM_WARPS][DEPTH];
  mask_t saved_mask_q [NUM_WARPS][DEPTH];

  logic [NUM_WARPS-1:0] push_en;
  idx_t                 push_idx [NUM_WARPS];

  // Only one branch arrives per cycle, so its split is computed once
  mask_t br_a, br_t, br_n;
  assign br_a = mask_q[br_warp];
  assign br_t = br_taken & br_a;
  assign br_n = br_a & ~br_t;

  // Next-state: init wins over branch, branch wins over sync on one warp
  always_comb begin
    logic init_hit, br_hit, sync_hit;
    idx_t top;
    // NOTE: every _d gets a default before any branch so no path can leave
    // it unassigned; an unassigned path would infer a latch.
    mask_d        = mask_q;
    sp_d          = sp_q;
    pending_d     = pending_q;
    redirect_pc_d = redirect_pc_q;
    redirect_d    = '0;
    err_ov_d      = 1'b0;
    err_un_d      = 1'b0;
    push_en       = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      push_idx[w] = idx_t'(sp_q[w]);
      top         = idx_t'(sp_q[w] - SP_ONE);
      init_hit    = init_valid && (init_warp == WID_W'(w));
      br_hit      = br_valid   && (br_warp   == WID_W'(w));
      sync_hit    = sync_valid && (sync_warp == WID_W'(w));
      if (init_hit) begin
        mask_d[w] = init_mask;
        sp_d[w]   = '0;
      end else if (br_hit) begin
        if (br_t != '0) begin
          redirect_d[w]    = 1'b1;
          redirect_pc_d[w] = br_target;
          if (br_n != '0) begin
            if (sp_q[w] != SP_FULL) begin
              push_en[w]                 = 1'b1;
              pending_d[w][push_idx[w]] = 1'b1;
              mask_d[w]                  = br_t;
              sp_d[w]                    = sp_q[w] + SP_ONE;
            end else begin
              err_ov_d = 1'b1;
            end
          end
        end
      end else if (sync_hit) begin
        if (sp_q[w] == '0) begin
          err_un_d = 1'b1;
        end else if (pending_q[w][top]) begin
          mask_d[w]         = alt_mask_q[w][top];
          redirect_d[w]     = 1'b1;
          redirect_pc_d[w]  = alt_pc_q[w][top];
          pending_d[w][top] = 1'b0;
        end else begin
          mask_d[w]        = saved_mask_q[w][top];
          redirect_d[w]    = 1'b1;
          redirect_pc_d[w] = sync_pc;
          sp_d[w]          = sp_q[w] - SP_ONE;
        end
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        mask_q[w]        <= '0;
        sp_q[w]          <= '0;
        pending_q[w]     <= '0;
        redirect_pc_q[w] <= '0;
      end
      redirect_q <= '0;
      err_ov_q   <= 1'b0;
      err_un_q   <= 1'b0;
    end else begin
      mask_q        <= mask_d;
      sp_q          <= sp_d;
      pending_q     <= pending_d;
      redirect_pc_q <= redirect_pc_d;
      redirect_q    <= redirect_d;
      err_ov_q      <= err_ov_d;
      err_un_q      <= err_un_d;
    end
  end

  // Stack payload write on push
  always_ff @(posedge clk) begin
    // NOTE: the payload array is deliberately not reset; it is only read
    // below sp, and every entry there was written by the push that
    // incremented sp.
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (push_en[w]) begin
        alt_mask_q[w][push_idx[w]]   <= br_n;
        alt_pc_q[w][push_idx[w]]     <= br_fallthru;
        saved_mask_q[w][push_idx[w]] <= br_a;
      end
    end
  end

  // Flatten per-warp registers onto the output buses
  always_comb begin
    active_mask_flat = '0;
    redirect_pc_flat = '0;
    stack_empty      = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      active_mask_flat[w*NUM_THREADS +: NUM_THREADS] = mask_q[w];
      redirect_pc_flat[w*PC_W +: PC_W]               = redirect_pc_q[w];
      stack_empty[w]                                 = (sp_q[w] == '0);
    end
  end

  assign redirect_vec  = redirect_q;
  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Scoreboard bench for simt_reconv_stack: the driver queues hand-computed
// expectations stamped with the cycle they must appear; a monitor pops and
// compares them on the falling edge.
module tb_simt_reconv_stack;
  localparam int NW = 8, NT = 8, D = 4, PW = 10, WW = 3;

  logic clk = 1'b0;
  logic rst, init_valid, br_valid, sync_valid;
  logic [WW-1:0] init_warp, br_warp, sync_warp;
  logic [NT-1:0] init_mask, br_taken;
  logic [PW-1:0] br_target, br_fallthru, sync_pc;
  logic [NW*NT-1:0] active_mask_flat;
  logic [NW-1:0] redirect_vec, stack_empty;
  logic [NW*PW-1:0] redirect_pc_flat;
  logic err_overflow, err_underflow;

  always #5 clk = ~clk;

  simt_reconv_stack #(.NUM_WARPS(NW), .NUM_THREADS(NT), .DEPTH(D), .PC_W(PW)) dut (
    .clk(clk), .rst(rst),
    .init_valid(init_valid), .init_warp(init_warp), .init_mask(init_mask),
    .br_valid(br_valid), .br_warp(br_warp), .br_taken(br_taken),
    .br_target(br_target), .br_fallthru(br_fallthru),
    .sync_valid(sync_valid), .sync_warp(sync_warp), .sync_pc(sync_pc),
    .active_mask_flat(active_mask_flat), .redirect_vec(redirect_vec),
    .redirect_pc_flat(redirect_pc_flat), .stack_empty(stack_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  typedef struct {
    int            cyc;
    int            warp;
    logic [NT-1:0] mask;
    logic          empty;
    logic [NW-1:0] rvec;
    logic [PW-1:0] rpc;
    logic          ov;
    logic          un;
    logic          fpc;
  } exp_t;

  exp_t q[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Queue an expectation for the cycle after the current stimulus
  task automatic expect_w(input int w, input logic [NT-1:0] m, input logic emp,
                          input logic [NW-1:0] rv, input logic [PW-1:0] pc,
                          input logic ov = 1'b0, input logic un = 1'b0,
                          input logic fpc = 1'b0);
    exp_t e;
    e.cyc = cyc + 1; e.warp = w; e.mask = m; e.empty = emp; e.rvec = rv;
    e.rpc = pc; e.ov = ov; e.un = un; e.fpc = fpc;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation due in this cycle
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc) check($sformatf("c%0d w%0d stamp", e.cyc, e.warp), cyc, e.cyc);
        check($sformatf("c%0d w%0d mask", e.cyc, e.warp), active_mask_flat[e.warp*NT +: NT], e.mask);
        check($sformatf("c%0d w%0d empty", e.cyc, e.warp), stack_empty[e.warp], e.empty);
        check($sformatf("c%0d w%0d rvec", e.cyc, e.warp), redirect_vec, e.rvec);
        if (e.rvec[e.warp] || e.fpc)
          check($sformatf("c%0d w%0d rpc", e.cyc, e.warp), redirect_pc_flat[e.warp*PW +: PW], e.rpc);
        check($sformatf("c%0d w%0d ovf", e.cyc, e.warp), err_overflow, e.ov);
        check($sformatf("c%0d w%0d unf", e.cyc, e.warp), err_underflow, e.un);
      end
    end
  end

  task automatic clr();
    rst = 1'b0; init_valid = 1'b0; br_valid = 1'b0; sync_valid = 1'b0;
    init_warp = '0; init_mask = '0; br_warp = '0; br_taken = '0;
    br_target = '0; br_fallthru = '0; sync_warp = '0; sync_pc = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    clr();
  endtask

  task automatic do_init(input int w, input logic [NT-1:0] m);
    init_valid = 1'b1; init_warp = WW'(w); init_mask = m;
  endtask

  task automatic do_br(input int w, input logic [NT-1:0] t, input logic [PW-1:0] tgt,
                       input logic [PW-1:0] ft);
    br_valid = 1'b1; br_warp = WW'(w); br_taken = t; br_target = tgt; br_fallthru = ft;
  endtask

  task automatic do_sync(input int w, input logic [PW-1:0] pc);
    sync_valid = 1'b1; sync_warp = WW'(w); sync_pc = pc;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    do_br(6, 8'hFF, 10'h3FF, 10'h3FE);  // ignored while in reset
    for (int w = 0; w < NW; w++) expect_w(w, 8'h00, 1'b1, 8'h00, 10'h000, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    do_reset();

    // Basic two-phase divergence on warp 2
    tick(); do_init(2, 8'hFF);                  expect_w(2, 8'hFF, 1'b1, 8'h00, 10'h000);
    tick(); do_br(2, 8'h0F, 10'h040, 10'h014);  expect_w(2, 8'h0F, 1'b0, 8'h04, 10'h040);
    tick(); do_sync(2, 10'h060);                expect_w(2, 8'hF0, 1'b0, 8'h04, 10'h014);
    tick(); do_sync(2, 10'h060);                expect_w(2, 8'hFF, 1'b1, 8'h04, 10'h060);

    // Uniform branches on warp 0; warp 2 redirect PC holds
    tick(); do_init(0, 8'h3C);
    expect_w(0, 8'h3C, 1'b1, 8'h00, 10'h000);
    expect_w(2, 8'hFF, 1'b1, 8'h00, 10'h060, 1'b0, 1'b0, 1'b1);
    tick(); do_br(0, 8'hC3, 10'h0A0, 10'h0A4);  expect_w(0, 8'h3C, 1'b1, 8'h00, 10'h000);
    tick(); do_br(0, 8'hFF, 10'h080, 10'h084);  expect_w(0, 8'h3C, 1'b1, 8'h01, 10'h080);

    // Nesting to full depth on warp 5, then overflow
    tick(); do_init(5, 8'hFF);                  expect_w(5, 8'hFF, 1'b1, 8'h00, 10'h000);
    tick(); do_br(5, 8'h7F, 10'h100, 10'h010);  expect_w(5, 8'h7F, 1'b0, 8'h20, 10'h100);
    tick(); do_br(5, 8'h3F, 10'h104, 10'h011);  expect_w(5, 8'h3F, 1'b0, 8'h20, 10'h104);
    tick(); do_br(5, 8'h1F, 10'h108, 10'h012);  expect_w(5, 8'h1F, 1'b0, 8'h20, 10'h108);
    tick(); do_br(5, 8'h0F, 10'h10C, 10'h013);  expect_w(5, 8'h0F, 1'b0, 8'h20, 10'h10C);
    tick(); do_br(5, 8'h07, 10'h110, 10'h014);  expect_w(5, 8'h0F, 1'b0, 8'h20, 10'h110, 1'b1);
    tick(); do_sync(5, 10'h200);                expect_w(5, 8'h10, 1'b0, 8'h20, 10'h013);
    tick(); do_sync(5, 10'h200);                expect_w(5, 8'h1F, 1'b0, 8'h20, 10'h200);

    // Underflow on a freshly started warp
    tick(); do_init(7, 8'hAA);                  expect_w(7, 8'hAA, 1'b1, 8'h00, 10'h000);
    tick(); do_sync(7, 10'h030);                expect_w(7, 8'hAA, 1'b1, 8'h00, 10'h000, 1'b0, 1'b1);

    // Branch on warp 1 and sync on warp 3 in the same cycle
    tick(); do_init(1, 8'h0F);                  expect_w(1, 8'h0F, 1'b1, 8'h00, 10'h000);
    tick(); do_init(3, 8'hF0);                  expect_w(3, 8'hF0, 1'b1, 8'h00, 10'h000);
    tick(); do_br(3, 8'h30, 10'h050, 10'h024);  expect_w(3, 8'h30, 1'b0, 8'h08, 10'h050);
    tick(); do_br(1, 8'h0F, 10'h070, 10'h074); do_sync(3, 10'h090);
    expect_w(1, 8'h0F, 1'b1, 8'h0A, 10'h070);
    expect_w(3, 8'hC0, 1'b0, 8'h0A, 10'h024);
    // Branch and sync on the same warp: sync dropped
    tick(); do_br(3, 8'h40, 10'h058, 10'h028); do_sync(3, 10'h090);
    expect_w(3, 8'h40, 1'b0, 8'h08, 10'h058);

    // Init overrides a branch to the same warp
    tick(); do_init(4, 8'hFF);                  expect_w(4, 8'hFF, 1'b1, 8'h00, 10'h000);
    tick(); do_init(4, 8'h33); do_br(4, 8'h0F, 10'h090, 10'h094);
    expect_w(4, 8'h33, 1'b1, 8'h00, 10'h000);

    // Reset in the middle of divergence on warp 6
    tick(); do_init(6, 8'hFF);                  expect_w(6, 8'hFF, 1'b1, 8'h00, 10'h000);
    tick(); do_br(6, 8'h0F, 10'h044, 10'h020);  expect_w(6, 8'h0F, 1'b0, 8'h40, 10'h044);
    tick(); do_br(6, 8'h03, 10'h048, 10'h021);  expect_w(6, 8'h03, 1'b0, 8'h40, 10'h048);
    do_reset();
    tick(); do_init(6, 8'hF0);                  expect_w(6, 8'hF0, 1'b1, 8'h00, 10'h000);
    tick(); do_br(6, 8'h30, 10'h04C, 10'h022);  expect_w(6, 8'h30, 1'b0, 8'h40, 10'h04C);
    tick(); do_sync(6, 10'h066);                expect_w(6, 8'hC0, 1'b0, 8'h40, 10'h022);
    tick(); do_sync(6, 10'h066);                expect_w(6, 8'hF0, 1'b1, 8'h40, 10'h066);

    tick();
    repeat (3) @(negedge clk);
    check("queue drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
